// File: rtl/frat_ckpt.sv
// Front-end register alias table with a circular pool of branch checkpoints.
// Latency: one cycle, ID inputs -> registered ar_* outputs.
// Backpressure: rename_rdy drops when fewer than ISSUE_W checkpoints are free; is_val is then ignored.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   is_*, rob_is_ptr    rename group from decode (lane i fields at [i*W +: W])
//   rename_rdy          group can be accepted this cycle
//   ret_*               ROB retire bus (lane k fields at [k*W +: W])
//   flush_val/_ckpt     mispredict restore of one checkpoint
//   ar_*                renamed group to allocate; source s of lane i at index 2*i+s
module frat_ckpt #(
  parameter int ISSUE_W  = 2,
  parameter int RET_W    = 4,
  parameter int NUM_AREG = 32,
  parameter int ROB_SIZE = 64,
  parameter int NUM_CKPT = 4,
  localparam int AW    = $clog2(NUM_AREG),
  localparam int RW    = $clog2(ROB_SIZE),
  localparam int CW    = $clog2(NUM_CKPT),
  localparam int TAG_W = $clog2((ROB_SIZE > NUM_AREG) ? ROB_SIZE : NUM_AREG)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ISSUE_W-1:0]         is_val,
  input  logic [ISSUE_W*AW-1:0]      is_rs1,
  input  logic [ISSUE_W*AW-1:0]      is_rs2,
  input  logic [ISSUE_W*AW-1:0]      is_rd,
  input  logic [ISSUE_W-1:0]         is_wr,
  input  logic [ISSUE_W-1:0]         is_br,
  input  logic [RW-1:0]              rob_is_ptr,
  output logic                       rename_rdy,
  input  logic [RET_W-1:0]           ret_val,
  input  logic [RET_W-1:0]           ret_wr,
  input  logic [RET_W*AW-1:0]        ret_rd,
  input  logic [RET_W*RW-1:0]        ret_robid,
  input  logic [RET_W-1:0]           ret_br,
  input  logic                       flush_val,
  input  logic [CW-1:0]              flush_ckpt,
  output logic [ISSUE_W-1:0]         ar_val,
  output logic [ISSUE_W*2*TAG_W-1:0] ar_src_tag,
  output logic [ISSUE_W*2-1:0]       ar_src_rf,
  output logic [ISSUE_W*RW-1:0]      ar_robid,
  output logic [ISSUE_W*CW-1:0]      ar_ckpt_id
);

  // Architectural table and checkpoint copies: rf=1 means tag is a PRF index,
  // rf=0 means tag is the ROB id of the in-flight producer.
  logic [NUM_AREG-1:0] tbl_rf;
  logic [TAG_W-1:0]    tbl_tag [NUM_AREG];
  logic [NUM_AREG-1:0] ck_rf   [NUM_CKPT];
  logic [TAG_W-1:0]    ck_tag  [NUM_CKPT][NUM_AREG];
  logic [CW:0]         head, tail;

  logic [CW:0]         used, head_nxt, tail_nxt, nalloc, nret;
  logic [CW+1:0]       free;
  logic [CW-1:0]       foff;
  logic                flush_ok;
  logic [ISSUE_W-1:0]  acc, wr_en;
  logic [NUM_CKPT-1:0] slot_vld;
  int                  nbr;

  logic [AW-1:0]       rs1 [ISSUE_W];
  logic [AW-1:0]       rs2 [ISSUE_W];
  logic [AW-1:0]       rd  [ISSUE_W];
  logic [RW-1:0]       lrob[ISSUE_W];
  logic [CW-1:0]       slot[ISSUE_W];
  logic [AW-1:0]       rrd [RET_W];
  logic [RW-1:0]       rrob[RET_W];
  logic [RET_W-1:0]    rhit_en;

  logic [NUM_AREG-1:0] wk_rf;
  logic [TAG_W-1:0]    wk_tag  [NUM_AREG];
  logic [NUM_AREG-1:0] snap_rf [ISSUE_W];
  logic [TAG_W-1:0]    snap_tag[ISSUE_W][NUM_AREG];
  logic [NUM_AREG-1:0] ckn_rf  [NUM_CKPT];
  logic [TAG_W-1:0]    ckn_tag [NUM_CKPT][NUM_AREG];

  logic [ISSUE_W*2*TAG_W-1:0] src_tag_f;
  logic [ISSUE_W*2-1:0]       src_rf_f;
  logic [ISSUE_W*RW-1:0]      robid_f;
  logic [ISSUE_W*CW-1:0]      slot_f;
  logic [AW-1:0]              rs;
  logic                       srf;
  logic [TAG_W-1:0]           stag;
  int                         rsum;

  // Pointers carry a wrap bit so full and empty are distinguishable.
  assign used       = tail - head;
  assign free       = (CW+2)'(NUM_CKPT) - {1'b0, used};
  assign rename_rdy = (free >= (CW+2)'(ISSUE_W));
  assign acc        = is_val & {ISSUE_W{rename_rdy & ~flush_val}};
  assign rhit_en    = ret_val & ret_wr;

  always_comb begin
    rsum = 0;
    for (int i = 0; i < ISSUE_W; i++) begin
      rs1[i] = is_rs1[i*AW +: AW];
      rs2[i] = is_rs2[i*AW +: AW];
      rd[i]  = is_rd[i*AW +: AW];
      rsum   = int'(rob_is_ptr) + i;
      if (rsum >= ROB_SIZE) rsum = rsum - ROB_SIZE;
      lrob[i]  = RW'(rsum);
      wr_en[i] = acc[i] & is_wr[i] & (rd[i] != '0);
    end
    for (int k = 0; k < RET_W; k++) begin
      rrd[k]  = ret_rd[k*AW +: AW];
      rrob[k] = ret_robid[k*RW +: RW];
    end
  end

  // Branch lanes take consecutive slots starting at tail, in lane order.
  always_comb begin
    nalloc = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      slot[i] = tail[CW-1:0] + nalloc[CW-1:0];
      if (acc[i] && is_br[i]) nalloc = nalloc + (CW+1)'(1);
    end
  end

  // Retired branches free the oldest slots; surplus ones are ignored.
  always_comb begin
    nbr = 0;
    for (int k = 0; k < RET_W; k++)
      if (ret_val[k] && ret_br[k]) nbr = nbr + 1;
    nret = (nbr > int'(used)) ? used : (CW+1)'(nbr);
  end

  always_comb begin
    foff     = flush_ckpt - head[CW-1:0];
    flush_ok = flush_val && ({1'b0, foff} < used);
    head_nxt = head + nret;
    tail_nxt = flush_ok ? (head + {1'b0, foff}) : (tail + nalloc);
    for (int c = 0; c < NUM_CKPT; c++)
      slot_vld[c] = ({1'b0, CW'(c) - head[CW-1:0]} < used);
  end

  // Next table: base (live or restored), then retires whose robid still owns
  // the entry, then issue writes in lane order. Snapshot i is taken after lane i.
  always_comb begin
    for (int a = 0; a < NUM_AREG; a++) begin
      wk_rf[a]  = flush_ok ? ck_rf[flush_ckpt][a]  : tbl_rf[a];
      wk_tag[a] = flush_ok ? ck_tag[flush_ckpt][a] : tbl_tag[a];
      for (int k = 0; k < RET_W; k++)
        if (rhit_en[k] && rrd[k] == AW'(a) && !wk_rf[a] && wk_tag[a] == TAG_W'(rrob[k])) begin
          wk_rf[a]  = 1'b1;
          wk_tag[a] = TAG_W'(a);
        end
    end
    for (int i = 0; i < ISSUE_W; i++) begin
      if (wr_en[i]) begin
        wk_rf[rd[i]]  = 1'b0;
        wk_tag[rd[i]] = TAG_W'(lrob[i]);
      end
      snap_rf[i] = wk_rf;
      for (int a = 0; a < NUM_AREG; a++) snap_tag[i][a] = wk_tag[a];
    end
  end

  // Live checkpoints track retirement so a later restore sees committed values.
  always_comb begin
    for (int c = 0; c < NUM_CKPT; c++) begin
      ckn_rf[c] = ck_rf[c];
      for (int a = 0; a < NUM_AREG; a++) begin
        ckn_tag[c][a] = ck_tag[c][a];
        if (slot_vld[c])
          for (int k = 0; k < RET_W; k++)
            if (rhit_en[k] && rrd[k] == AW'(a) && !ckn_rf[c][a] &&
                ckn_tag[c][a] == TAG_W'(rrob[k])) begin
              ckn_rf[c][a]  = 1'b1;
              ckn_tag[c][a] = TAG_W'(a);
            end
      end
    end
    for (int i = 0; i < ISSUE_W; i++)
      if (acc[i] && is_br[i]) begin
        ckn_rf[slot[i]] = snap_rf[i];
        for (int a = 0; a < NUM_AREG; a++) ckn_tag[slot[i]][a] = snap_tag[i][a];
      end
  end

  // Source rename: table, then same-cycle retire, then older-lane bypass, then x0.
  always_comb begin
    src_rf_f  = '0;
    src_tag_f = '0;
    robid_f   = '0;
    slot_f    = '0;
    rs        = '0;
    srf       = 1'b0;
    stag      = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      robid_f[i*RW +: RW] = lrob[i];
      slot_f[i*CW +: CW]  = slot[i];
      for (int s = 0; s < 2; s++) begin
        rs   = (s == 0) ? rs1[i] : rs2[i];
        srf  = tbl_rf[rs];
        stag = tbl_tag[rs];
        for (int k = 0; k < RET_W; k++)
          if (!srf && rhit_en[k] && stag == TAG_W'(rrob[k])) begin
            srf  = 1'b1;
            stag = TAG_W'(rrd[k]);
          end
        for (int j = 0; j < i; j++)
          if (wr_en[j] && rd[j] == rs) begin
            srf  = 1'b0;
            stag = TAG_W'(lrob[j]);
          end
        if (rs == '0) begin
          srf  = 1'b1;
          stag = '0;
        end
        src_rf_f[2*i+s]                 = srf;
        src_tag_f[(2*i+s)*TAG_W +: TAG_W] = stag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tbl_rf <= '1;
      for (int a = 0; a < NUM_AREG; a++) tbl_tag[a] <= TAG_W'(a);
      for (int c = 0; c < NUM_CKPT; c++) begin
        ck_rf[c] <= '1;
        for (int a = 0; a < NUM_AREG; a++) ck_tag[c][a] <= TAG_W'(a);
      end
      head       <= '0;
      tail       <= '0;
      ar_val     <= '0;
      ar_src_tag <= '0;
      ar_src_rf  <= '0;
      ar_robid   <= '0;
      ar_ckpt_id <= '0;
    end else begin
      tbl_rf <= wk_rf;
      for (int a = 0; a < NUM_AREG; a++) tbl_tag[a] <= wk_tag[a];
      for (int c = 0; c < NUM_CKPT; c++) begin
        ck_rf[c] <= ckn_rf[c];
        for (int a = 0; a < NUM_AREG; a++) ck_tag[c][a] <= ckn_tag[c][a];
      end
      head       <= head_nxt;
      tail       <= tail_nxt;
      ar_val     <= acc;
      ar_src_tag <= src_tag_f;
      ar_src_rf  <= src_rf_f;
      ar_robid   <= robid_f;
      ar_ckpt_id <= slot_f;
    end
  end

  // Retiring a branch with no checkpoint held, or restoring a free slot, is a
  // protocol error upstream; the hardware ignores it.
  assert property (@(posedge clk) disable iff (!rst) nbr <= int'(used));
  assert property (@(posedge clk) disable iff (!rst) !(flush_val && !flush_ok));

endmodule

// File: tb/tb_frat_ckpt.sv
module tb_frat_ckpt;
  localparam int ISSUE_W = 2;
  localparam int RET_W   = 4;
  localparam int AW      = 5;
  localparam int RW      = 6;
  localparam int CW      = 2;
  localparam int TAG_W   = 6;

  logic                       clk = 1'b0;
  logic                       rst = 1'b0;
  logic [ISSUE_W-1:0]         is_val, is_wr, is_br;
  logic [ISSUE_W*AW-1:0]      is_rs1, is_rs2, is_rd;
  logic [RW-1:0]              rob_is_ptr;
  logic                       rename_rdy;
  logic [RET_W-1:0]           ret_val, ret_wr, ret_br;
  logic [RET_W*AW-1:0]        ret_rd;
  logic [RET_W*RW-1:0]        ret_robid;
  logic                       flush_val;
  logic [CW-1:0]              flush_ckpt;
  logic [ISSUE_W-1:0]         ar_val;
  logic [ISSUE_W*2*TAG_W-1:0] ar_src_tag;
  logic [ISSUE_W*2-1:0]       ar_src_rf;
  logic [ISSUE_W*RW-1:0]      ar_robid;
  logic [ISSUE_W*CW-1:0]      ar_ckpt_id;

  frat_ckpt dut (
    .clk(clk), .rst(rst),
    .is_val(is_val), .is_rs1(is_rs1), .is_rs2(is_rs2), .is_rd(is_rd),
    .is_wr(is_wr), .is_br(is_br), .rob_is_ptr(rob_is_ptr), .rename_rdy(rename_rdy),
    .ret_val(ret_val), .ret_wr(ret_wr), .ret_rd(ret_rd), .ret_robid(ret_robid),
    .ret_br(ret_br), .flush_val(flush_val), .flush_ckpt(flush_ckpt),
    .ar_val(ar_val), .ar_src_tag(ar_src_tag), .ar_src_rf(ar_src_rf),
    .ar_robid(ar_robid), .ar_ckpt_id(ar_ckpt_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lane; int rf1; int tag1; int rf2; int tag2; int rob; int chk; int ck;
  } exp_t;

  exp_t expq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic ex(input int lane, input int rf1, input int tag1, input int rf2,
                    input int tag2, input int rob, input int chkck, input int ck);
    exp_t e;
    e.lane = lane; e.rf1 = rf1; e.tag1 = tag1; e.rf2 = rf2; e.tag2 = tag2;
    e.rob = rob; e.chk = chkck; e.ck = ck;
    expq.push_back(e);
  endtask

  task automatic clr();
    is_val = '0; is_wr = '0; is_br = '0;
    is_rs1 = '0; is_rs2 = '0; is_rd = '0; rob_is_ptr = '0;
    ret_val = '0; ret_wr = '0; ret_br = '0; ret_rd = '0; ret_robid = '0;
    flush_val = 1'b0; flush_ckpt = '0;
  endtask

  task automatic lane(input int i, input int r1, input int r2, input int d,
                      input bit w, input bit b);
    is_val[i] = 1'b1;
    is_rs1[i*AW +: AW] = AW'(r1);
    is_rs2[i*AW +: AW] = AW'(r2);
    is_rd[i*AW +: AW]  = AW'(d);
    is_wr[i] = w;
    is_br[i] = b;
  endtask

  task automatic ret(input int k, input int d, input int rob, input bit w, input bit b);
    ret_val[k] = 1'b1;
    ret_wr[k]  = w;
    ret_br[k]  = b;
    ret_rd[k*AW +: AW]    = AW'(d);
    ret_robid[k*RW +: RW] = RW'(rob);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every valid output lane must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < ISSUE_W; i++) begin
        if (ar_val[i]) begin
          if (expq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_lane lane=%0d actual_val=1 required_val=0", i);
          end else begin
            exp_t e;
            e = expq.pop_front();
            chk("lane_idx", i, e.lane);
            chk("src1_rf",  ar_src_rf[2*i],   e.rf1);
            chk("src1_tag", ar_src_tag[(2*i)*TAG_W +: TAG_W], e.tag1);
            chk("src2_rf",  ar_src_rf[2*i+1], e.rf2);
            chk("src2_tag", ar_src_tag[(2*i+1)*TAG_W +: TAG_W], e.tag2);
            chk("robid",    ar_robid[i*RW +: RW], e.rob);
            if (e.chk != 0) chk("ckpt_id", ar_ckpt_id[i*CW +: CW], e.ck);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    #2;
    chk("rst_ar_val", ar_val, 0);
    chk("rst_src_tag", ar_src_tag, 0);
    chk("rst_src_rf", ar_src_rf, 0);
    chk("rst_robid", ar_robid, 0);
    chk("rst_rdy", rename_rdy, 1);
    step(); step();
    rst = 1'b1;

    // basic table read
    clr(); rob_is_ptr = 0; lane(0, 5, 0, 0, 0, 0);
    ex(0, 1, 5, 1, 0, 0, 0, 0); step();
    // same-group dependency
    clr(); rob_is_ptr = 10; lane(0, 1, 2, 3, 1, 0); lane(1, 3, 0, 0, 0, 0);
    ex(0, 1, 1, 1, 2, 10, 0, 0); ex(1, 0, 10, 1, 0, 11, 0, 0); step();
    clr(); rob_is_ptr = 12; lane(0, 3, 6, 0, 0, 0);
    ex(0, 0, 10, 1, 6, 12, 0, 0); step();
    // same-cycle retire override
    clr(); rob_is_ptr = 20; lane(0, 0, 0, 7, 1, 0);
    ex(0, 1, 0, 1, 0, 20, 0, 0); step();
    clr(); rob_is_ptr = 21; lane(0, 1, 7, 0, 0, 0); ret(0, 7, 20, 1, 0);
    ex(0, 1, 1, 1, 7, 21, 0, 0); step();
    clr(); rob_is_ptr = 22; lane(0, 3, 7, 0, 0, 0);
    ex(0, 0, 10, 1, 7, 22, 0, 0); step();
    // write-port priority: issue beats retire, youngest lane wins
    clr(); rob_is_ptr = 23; lane(0, 0, 0, 4, 1, 0);
    ex(0, 1, 0, 1, 0, 23, 0, 0); step();
    clr(); rob_is_ptr = 24; lane(0, 4, 0, 4, 1, 0); lane(1, 4, 0, 4, 1, 0);
    ret(0, 4, 23, 1, 0);
    ex(0, 1, 4, 1, 0, 24, 0, 0); ex(1, 0, 24, 1, 0, 25, 0, 0); step();
    clr(); rob_is_ptr = 26; lane(0, 4, 0, 0, 0, 0); ret(0, 4, 24, 1, 0);
    ex(0, 0, 25, 1, 0, 26, 0, 0); step();
    // checkpoint then restore
    clr(); rob_is_ptr = 30; lane(0, 9, 0, 9, 1, 1);
    ex(0, 1, 9, 1, 0, 30, 1, 0); step();
    chk("rdy_after_1ck", rename_rdy, 1);
    clr(); rob_is_ptr = 35; lane(0, 9, 0, 9, 1, 0);
    ex(0, 0, 30, 1, 0, 35, 0, 0); step();
    clr(); rob_is_ptr = 36; lane(0, 9, 0, 0, 0, 0); flush_val = 1'b1; flush_ckpt = 0;
    step();
    chk("flush_drop_val", ar_val, 0);
    chk("rdy_after_flush", rename_rdy, 1);
    clr(); rob_is_ptr = 36; lane(0, 9, 4, 0, 0, 0);
    ex(0, 0, 30, 0, 25, 36, 0, 0); step();
    // fill the pool
    clr(); rob_is_ptr = 40; lane(0, 9, 3, 0, 0, 1); lane(1, 7, 0, 0, 0, 1);
    ex(0, 0, 30, 0, 10, 40, 1, 0); ex(1, 1, 7, 1, 0, 41, 1, 1); step();
    chk("rdy_2ck", rename_rdy, 1);
    clr(); rob_is_ptr = 42; lane(0, 0, 0, 0, 0, 1);
    ex(0, 1, 0, 1, 0, 42, 1, 2); step();
    chk("rdy_3ck", rename_rdy, 0);
    clr(); rob_is_ptr = 43; lane(0, 1, 1, 0, 0, 0);
    step();
    chk("not_rdy_drop", ar_val, 0);
    // branch retire frees head; retire of robid 30 updates live checkpoints
    clr(); ret(0, 0, 40, 0, 1); ret(1, 9, 30, 1, 0);
    step();
    chk("rdy_after_retbr", rename_rdy, 1);
    clr(); flush_val = 1'b1; flush_ckpt = 1; ret(0, 3, 10, 1, 0);
    step();
    chk("flush2_drop_val", ar_val, 0);
    chk("rdy_after_flush2", rename_rdy, 1);
    clr(); rob_is_ptr = 50; lane(0, 9, 3, 0, 0, 0); lane(1, 4, 9, 0, 0, 1);
    ex(0, 1, 9, 1, 3, 50, 0, 0); ex(1, 0, 25, 1, 9, 51, 1, 1); step();
    clr(); rob_is_ptr = 52; lane(0, 0, 0, 0, 0, 1);
    ex(0, 1, 0, 1, 0, 52, 1, 2); step();
    // reset in the middle of traffic
    clr(); rob_is_ptr = 53; lane(0, 0, 0, 0, 0, 1);
    step();
    chk("pre_reset_val", ar_val, 1);
    chk("pre_reset_rdy", rename_rdy, 0);
    clr();
    rst = 1'b0;
    #1;
    chk("midrst_val", ar_val, 0);
    chk("midrst_rdy", rename_rdy, 1);
    chk("midrst_rf", ar_src_rf, 0);
    step();
    rst = 1'b1;
    // table back to identity; robid wraps mod ROB_SIZE
    clr(); rob_is_ptr = 63; lane(0, 4, 0, 5, 1, 0); lane(1, 5, 9, 0, 0, 0);
    ex(0, 1, 4, 1, 0, 63, 0, 0); ex(1, 0, 63, 1, 9, 0, 0, 0); step();
    clr();
    step(); step(); step();
    chk("queue_drain", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
